// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 pipelined-classic bus bundle shared by the BRAM slave and its masters.
// Clock and reset travel with the bus so a slave needs only one port.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_sm, ack, err, rty,
        output cyc, stb, we, adr, sel, dat_ms, cti, bte
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wb_bram_burst.sv
// Wishbone block-RAM slave with zero-wait writes, configurable read latency
// and linear incrementing-burst reads that stream one word per cycle.
// ack and err are decoded combinationally from the registered read state so
// that writes and out-of-range accesses answer in the request cycle.
module wb_bram_burst #(
    parameter int MEM_ADR_WIDTH = 11,
    parameter int READ_WAIT     = 0,
    parameter int BURST_EN      = 1
) (
    wshb_if.slave wb_s
);
    localparam int DEPTH = 1 << MEM_ADR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                   state_q;
    logic [2:0]               cnt_q;
    logic [31:0]              dat_sm_q;
    logic [31:0]              mem [DEPTH];

    logic                     req;
    logic                     in_range;
    logic                     burst_type_ok;
    logic                     burst_read;
    logic [MEM_ADR_WIDTH-1:0] word_idx;
    logic [MEM_ADR_WIDTH-1:0] rd_adr_d;
    logic [3:0]               wr_en;
    logic                     ack;
    logic                     err;

    assign req      = wb_s.cyc & wb_s.stb;
    assign in_range = ((wb_s.adr >> (MEM_ADR_WIDTH + 2)) == 32'd0);
    assign word_idx = wb_s.adr[MEM_ADR_WIDTH+1:2];

    // A beat may be streamed only for linear incrementing bursts when bursts are enabled.
    assign burst_type_ok = (BURST_EN != 0) && (wb_s.cti == 3'b010) && (wb_s.bte == 2'b00);
    assign burst_read    = req & in_range & ~wb_s.we & burst_type_ok;

    // While streaming, fetch the following word so it is ready on the next beat;
    // the increment wraps naturally at the top of the array.
    assign rd_adr_d = ((state_q == DATA) && burst_read)
                      ? word_idx + {{(MEM_ADR_WIDTH-1){1'b0}}, 1'b1}
                      : word_idx;

    // Writes are only accepted from IDLE; a write seen mid-read is a protocol
    // violation and is dropped.  Reset also blocks writes.
    assign wr_en = (!wb_s.rst && req && in_range && wb_s.we && (state_q == IDLE))
                   ? wb_s.sel : 4'b0000;

    assign ack = ~wb_s.rst & req & in_range &
                 (((state_q == IDLE) & wb_s.we) | ((state_q == DATA) & ~wb_s.we));
    assign err = ~wb_s.rst & req & ~in_range;

    assign wb_s.ack    = ack;
    assign wb_s.err    = err;
    assign wb_s.rty    = 1'b0;
    assign wb_s.dat_sm = dat_sm_q;

    // Read sequencing: IDLE -> (WAIT while counting down) -> DATA, staying in DATA
    // for linear bursts and falling back to IDLE on anything unexpected.
    always_ff @(posedge wb_s.clk or posedge wb_s.rst) begin
        if (wb_s.rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else if (!req || !in_range) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!wb_s.we) begin
                        if (READ_WAIT > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= 3'(READ_WAIT);
                        end else begin
                            state_q <= DATA;
                            cnt_q   <= 3'd0;
                        end
                    end
                end
                WAIT: begin
                    if (wb_s.we) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                    end else if (cnt_q == 3'd1) begin
                        state_q <= DATA;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DATA: begin
                    if (burst_read) begin
                        state_q <= DATA;
                    end else begin
                        state_q <= IDLE;
                    end
                    cnt_q <= 3'd0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    // Byte-lane writes into the array; contents deliberately survive reset.
    always_ff @(posedge wb_s.clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[word_idx][8*i +: 8] <= wb_s.dat_ms[8*i +: 8];
            end
        end
    end

    // Registered read port, refreshed every cycle from the selected word.
    always_ff @(posedge wb_s.clk or posedge wb_s.rst) begin
        if (wb_s.rst) begin
            dat_sm_q <= 32'd0;
        end else begin
            dat_sm_q <= mem[rd_adr_d];
        end
    end
endmodule

// File: tb/tb_wb_bram_burst.sv
// Randomized bench for wb_bram_burst: a fast instance (no read wait) and a slow
// one (three read waits) are driven over their own buses and compared against
// a word-array memory model plus latency rules stated in bus-beat terms.
module tb_wb_bram_burst;
    localparam int AW    = 11;
    localparam int WORDS = 1 << AW;
    localparam int RW1   = 3;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wshb_if bus0 (.clk(clk), .rst(rst));
    wshb_if bus1 (.clk(clk), .rst(rst));

    wb_bram_burst #(.MEM_ADR_WIDTH(AW), .READ_WAIT(0),   .BURST_EN(1)) u_dutFast (.wb_s(bus0));
    wb_bram_burst #(.MEM_ADR_WIDTH(AW), .READ_WAIT(RW1), .BURST_EN(1)) u_dutSlow (.wb_s(bus1));

    logic        cycR [2];
    logic        stbR [2];
    logic        weR  [2];
    logic [31:0] adrR [2];
    logic [31:0] datR [2];
    logic [3:0]  selR [2];
    logic [2:0]  ctiR [2];
    logic [1:0]  bteR [2];

    assign bus0.cyc = cycR[0];  assign bus1.cyc = cycR[1];
    assign bus0.stb = stbR[0];  assign bus1.stb = stbR[1];
    assign bus0.we  = weR[0];   assign bus1.we  = weR[1];
    assign bus0.adr = adrR[0];  assign bus1.adr = adrR[1];
    assign bus0.dat_ms = datR[0]; assign bus1.dat_ms = datR[1];
    assign bus0.sel = selR[0];  assign bus1.sel = selR[1];
    assign bus0.cti = ctiR[0];  assign bus1.cti = ctiR[1];
    assign bus0.bte = bteR[0];  assign bus1.bte = bteR[1];

    logic [1:0]  ackO;
    logic [1:0]  errO;
    logic [1:0]  rtyO;
    logic [31:0] datO [2];

    assign ackO    = {bus1.ack, bus0.ack};
    assign errO    = {bus1.err, bus0.err};
    assign rtyO    = {bus1.rty, bus0.rty};
    assign datO[0] = bus0.dat_sm;
    assign datO[1] = bus1.dat_sm;

    logic [31:0] model [2][WORDS];
    int          rwOf  [2];
    int          total;
    int          bad;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Drives one bus cycle starting just after a rising edge.
    task automatic applyStimulus(input int d, input logic c, input logic w,
                                 input logic [31:0] a, input logic [31:0] dt,
                                 input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt);
        @(posedge clk);
        #1;
        cycR[d] = c;  stbR[d] = c;  weR[d] = w;
        adrR[d] = a;  datR[d] = dt; selR[d] = sl;
        ctiR[d] = ct; bteR[d] = bt;
    endtask

    task automatic busIdle(input int d);
        applyStimulus(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 3'b000, 2'b00);
    endtask

    task automatic doWrite(input int d, input int word, input logic [31:0] dt,
                           input logic [3:0] sl, input logic [2:0] ct, input bit chk);
        int w;
        w = word % WORDS;
        applyStimulus(d, 1'b1, 1'b1, 32'(w) << 2, dt, sl, ct, 2'b00);
        @(negedge clk);
        if (chk) begin
            checkOutput("wr_ack", {31'd0, ackO[d]}, 32'd1);
            checkOutput("wr_err", {31'd0, errO[d]}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (sl[i]) model[d][w][8*i +: 8] = dt[8*i +: 8];
        end
    endtask

    // One read beat: counts non-ack cycles before the ack and checks the data.
    task automatic readBeat(input int d, input int word, input logic [2:0] ct,
                            input logic [1:0] bt, input int expWaits, input string tag);
        int w;
        int waits;
        w = word % WORDS;
        applyStimulus(d, 1'b1, 1'b0, 32'(w) << 2, $urandom, 4'hF, ct, bt);
        @(negedge clk);
        waits = 0;
        while (ackO[d] !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        checkOutput({tag, "_lat"}, 32'(waits), 32'(expWaits));
        checkOutput({tag, "_dat"}, datO[d], model[d][w]);
    endtask

    task automatic classicRead(input int d, input int word, input string tag);
        readBeat(d, word, 3'b000, 2'b00, 1 + rwOf[d], tag);
    endtask

    // Linear bursts stream after the first beat; other burst types re-pay full latency.
    task automatic burstRead(input int d, input int start, input int n,
                             input logic [1:0] bt, input string tag);
        for (int b = 0; b < n; b++) begin
            readBeat(d, start + b, (b == n - 1) ? 3'b111 : 3'b010, bt,
                     (b == 0 || bt != 2'b00) ? 1 + rwOf[d] : 0, tag);
        end
    endtask

    task automatic oorAccess(input int d, input logic [31:0] a, input logic w, input string tag);
        applyStimulus(d, 1'b1, w, a, $urandom, 4'hF, 3'b000, 2'b00);
        @(negedge clk);
        checkOutput({tag, "_err"}, {31'd0, errO[d]}, 32'd1);
        checkOutput({tag, "_ack"}, {31'd0, ackO[d]}, 32'd0);
        busIdle(d);
    endtask

    // A write issued while a read is in flight must be ignored entirely.
    task automatic violation(input int d, input int word);
        applyStimulus(d, 1'b1, 1'b0, 32'(word) << 2, 32'd0, 4'hF, 3'b000, 2'b00);
        @(negedge clk);
        checkOutput("viol_req_ack", {31'd0, ackO[d]}, 32'd0);
        applyStimulus(d, 1'b1, 1'b1, 32'(word) << 2, ~model[d][word], 4'hF, 3'b000, 2'b00);
        @(negedge clk);
        checkOutput("viol_wr_ack", {31'd0, ackO[d]}, 32'd0);
        busIdle(d);
        classicRead(d, word, "viol_rd");
    endtask

    task automatic randomOps(input int d, input int iters);
        int          op;
        int          word;
        logic [31:0] a;
        for (int it = 0; it < iters; it++) begin
            op   = $urandom_range(0, 4);
            word = $urandom_range(0, WORDS - 1);
            case (op)
                0: doWrite(d, word, $urandom, 4'($urandom),
                           ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b000, 1'b1);
                1: classicRead(d, word, "rnd_rd");
                2: burstRead(d, word, $urandom_range(1, 6),
                             ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                             "rnd_burst");
                3: begin
                    a = $urandom;
                    a[13 + $urandom_range(0, 18)] = 1'b1;
                    oorAccess(d, a, 1'($urandom_range(0, 1)), "rnd_oor");
                    classicRead(d, int'(a[12:2]), "rnd_oor_rd");
                end
                default: begin
                    doWrite(d, word, $urandom, 4'hF, 3'b000, 1'b1);
                    classicRead(d, word, "rnd_wr_rd");
                end
            endcase
            if ($urandom_range(0, 1) != 0) busIdle(d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total   = 0;
        bad     = 0;
        rwOf[0] = 0;
        rwOf[1] = RW1;
        for (int d = 0; d < 2; d++) begin
            cycR[d] = 1'b0; stbR[d] = 1'b0; weR[d] = 1'b0; adrR[d] = 32'd0;
            datR[d] = 32'd0; selR[d] = 4'h0; ctiR[d] = 3'b000; bteR[d] = 2'b00;
        end

        // Reset state, including a write request that must be ignored under reset.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cycR[0] = 1'b1; stbR[0] = 1'b1; weR[0] = 1'b1; selR[0] = 4'hF;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_ack", {31'd0, ackO[d]}, 32'd0);
            checkOutput("rst_err", {31'd0, errO[d]}, 32'd0);
            checkOutput("rst_rty", {31'd0, rtyO[d]}, 32'd0);
            checkOutput("rst_dat", datO[d], 32'd0);
        end
        @(posedge clk);
        #1;
        cycR[0] = 1'b0; stbR[0] = 1'b0; weR[0] = 1'b0;
        rst = 1'b0;

        // Fill both memories so every word has a known value.
        for (int i = 0; i < WORDS; i++) doWrite(0, i, 32'(i), 4'hF, 3'b000, 1'b0);
        busIdle(0);
        for (int i = 0; i < WORDS; i++) doWrite(1, i, $urandom, 4'hF, 3'b000, 1'b0);
        busIdle(1);

        // Full write, byte-lane overwrite, then an immediate read-back.
        doWrite(0, 4, 32'hDEADBEEF, 4'hF, 3'b000, 1'b1);
        doWrite(0, 4, 32'h00000055, 4'h1, 3'b000, 1'b1);
        classicRead(0, 4, "bytelane");
        checkOutput("bytelane_val", datO[0], 32'hDEADBE55);
        busIdle(0);

        // Slow instance: classic read with three wait states.
        doWrite(1, 8, 32'hA5A5_1234, 4'hF, 3'b000, 1'b1);
        classicRead(1, 8, "slow_rd");
        checkOutput("slow_val", datO[1], 32'hA5A5_1234);
        busIdle(1);

        // Eight-beat linear burst over the identity-filled region.
        burstRead(0, 32'h100 >> 2, 8, 2'b00, "burst8");
        checkOutput("burst8_last", datO[0], 32'h47);
        classicRead(0, 17, "after_burst");
        busIdle(0);

        // Burst wrapping past the top of the array.
        burstRead(0, WORDS - 2, 4, 2'b00, "wrap");
        checkOutput("wrap_last", datO[0], 32'd1);
        busIdle(0);

        // Non-linear bursts degrade to classic beats on both instances.
        burstRead(0, 200, 4, 2'b01, "bte_fast");
        busIdle(0);
        burstRead(1, 300, 3, 2'b10, "bte_slow");
        busIdle(1);
        burstRead(1, 400, 5, 2'b00, "lin_slow");
        busIdle(1);

        // Out-of-range read and write; word 0 must stay intact.
        oorAccess(0, 32'h0001_0000, 1'b0, "oor_rd");
        oorAccess(0, 32'h0001_0000, 1'b1, "oor_wr");
        classicRead(0, 0, "oor_chk");
        busIdle(0);

        // Protocol violations during DATA (fast) and WAIT (slow).
        violation(0, 50);
        violation(1, 60);

        // Dropping the request during the wait period restarts the latency.
        applyStimulus(1, 1'b1, 1'b0, 32'd70 << 2, 32'd0, 4'hF, 3'b000, 2'b00);
        @(negedge clk);
        busIdle(1);
        classicRead(1, 71, "drop_rd");
        busIdle(1);

        // Reset pulsed on the fourth beat of a burst.
        readBeat(0, 128, 3'b010, 2'b00, 1, "rstb");
        readBeat(0, 129, 3'b010, 2'b00, 0, "rstb");
        readBeat(0, 130, 3'b010, 2'b00, 0, "rstb");
        applyStimulus(0, 1'b1, 1'b0, 32'd131 << 2, 32'd0, 4'hF, 3'b010, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstb_ack", {31'd0, ackO[0]}, 32'd0);
        checkOutput("rstb_dat", datO[0], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycR[0] = 1'b0;
        stbR[0] = 1'b0;
        classicRead(0, 133, "post_rst");
        busIdle(0);

        // Randomized traffic on both instances.
        randomOps(0, 80);
        busIdle(0);
        randomOps(1, 50);
        busIdle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
